// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB-to-APB bridge: address decode, address/data pipeline
// toward the APB control FSM, and a two-cycle ERROR responder for bad transfers.
module ahb_slave_interface #(
  parameter logic [31:0] BASE0       = 32'h8000_0000,
  parameter logic [31:0] BASE1       = 32'h8400_0000,
  parameter logic [31:0] BASE2       = 32'h8800_0000,
  parameter int          REGION_BITS = 26
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        valid,
  output logic [2:0]  tempselx,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic        err_hready
);

  typedef enum logic [1:0] {E_IDLE, E_ERR1, E_ERR2} estate_e;

  localparam logic [2:0][31:0] BASES = {BASE2, BASE1, BASE0};

  estate_e     estate_q, estate_d;
  logic [31:0] haddr1_q, haddr2_q, hwdata1_q, hwdata2_q;
  logic        hwrite_q;
  logic        active, illegal, err_req;

  // Region match on the upper address bits only; regions never overlap.
  for (genvar g = 0; g < 3; g++) begin : g_sel
    assign tempselx[g] = (Haddr[31:REGION_BITS] == BASES[g][31:REGION_BITS]);
  end

  assign active  = Htrans[1];
  assign illegal = (Hsize > 3'd2) |
                   ((Hsize == 3'd1) & Haddr[0]) |
                   ((Hsize == 3'd2) & (Haddr[1:0] != 2'b00));
  assign err_req = Hreadyin & active & ((tempselx == 3'b000) | illegal);
  assign valid   = Hreadyin & active & (tempselx != 3'b000) & ~illegal & (estate_q != E_ERR1);
  assign Hrdata  = Prdata;

  // Pipeline advances on every accepted cycle regardless of transfer type.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite_q  <= 1'b0;
    end else if (Hreadyin) begin
      haddr1_q  <= Haddr;
      haddr2_q  <= haddr1_q;
      hwdata1_q <= Hwdata;
      hwdata2_q <= hwdata1_q;
      hwrite_q  <= Hwrite;
    end
  end

  assign Haddr1    = haddr1_q;
  assign Haddr2    = haddr2_q;
  assign Hwdata1   = hwdata1_q;
  assign Hwdata2   = hwdata2_q;
  assign Hwritereg = hwrite_q;

  always_ff @(posedge Hclk) begin
    if (Hreset) estate_q <= E_IDLE;
    else        estate_q <= estate_d;
  end

  always_comb begin
    estate_d   = estate_q;
    Hresp      = 2'b00;
    err_hready = 1'b1;
    case (estate_q)
      E_IDLE: if (err_req) estate_d = E_ERR1;
      E_ERR1: begin
        Hresp      = 2'b01;
        err_hready = 1'b0;
        estate_d   = E_ERR2;
      end
      E_ERR2: begin
        Hresp    = 2'b01;
        estate_d = err_req ? E_ERR1 : E_IDLE;
      end
      default: estate_d = E_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Scoreboard bench for ahb_slave_interface: per-cycle expected register/response
// state is queued when stimulus is driven and compared after the clock edge.
module tb_ahb_slave_interface;

  logic        Hclk = 1'b0;
  logic        Hreset = 1'b1;
  logic [1:0]  Htrans = 2'b00;
  logic [2:0]  Hsize = 3'd0;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b1;
  logic [31:0] Haddr = '0;
  logic [31:0] Hwdata = '0;
  logic [31:0] Prdata = '0;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic        Hwritereg;
  logic [1:0]  Hresp;
  logic        err_hready;

  ahb_slave_interface dut (
    .Hclk(Hclk), .Hreset(Hreset), .Htrans(Htrans), .Hsize(Hsize), .Hwrite(Hwrite),
    .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .valid(valid), .tempselx(tempselx), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata1(Hwdata1), .Hwdata2(Hwdata2), .Hwritereg(Hwritereg), .Hrdata(Hrdata),
    .Hresp(Hresp), .err_hready(err_hready)
  );

  always #5 Hclk = ~Hclk;

  typedef struct {
    logic [31:0] a1, a2, w1, w2;
    logic        wr;
    logic [1:0]  resp;
    logic        hrdy;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk = 0;
  int          n_fail = 0;

  // Reference state, updated from the stimulus as each cycle is driven
  logic [31:0] m_a1 = '0, m_a2 = '0, m_w1 = '0, m_w2 = '0;
  logic        m_wr = 1'b0;
  int          m_es = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One bus cycle: drive, check combinational decode, queue expected post-edge state,
  // then pop and compare after the edge. eerr says this cycle should start an ERROR.
  task automatic step(input logic rst, input logic [1:0] tr, input logic [2:0] sz,
                      input logic wr, input logic rdy, input logic [31:0] a,
                      input logic [31:0] wd, input logic ev, input logic [2:0] esel,
                      input logic eerr);
    exp_t e, g;
    @(negedge Hclk);
    Hreset = rst; Htrans = tr; Hsize = sz; Hwrite = wr; Hreadyin = rdy;
    Haddr = a; Hwdata = wd; Prdata = $urandom;
    #1;
    chk("valid", {31'd0, valid}, {31'd0, ev});
    chk("tempselx", {29'd0, tempselx}, {29'd0, esel});
    chk("Hrdata", Hrdata, Prdata);
    if (rst) begin
      m_a1 = '0; m_a2 = '0; m_w1 = '0; m_w2 = '0; m_wr = 1'b0; m_es = 0;
    end else begin
      if (rdy) begin
        m_a2 = m_a1; m_a1 = a; m_w2 = m_w1; m_w1 = wd; m_wr = wr;
      end
      case (m_es)
        1:       m_es = 2;
        default: m_es = eerr ? 1 : 0;
      endcase
    end
    e.a1 = m_a1; e.a2 = m_a2; e.w1 = m_w1; e.w2 = m_w2; e.wr = m_wr;
    e.resp = (m_es != 0) ? 2'b01 : 2'b00;
    e.hrdy = (m_es != 1);
    sb_q.push_back(e);
    @(posedge Hclk);
    #1;
    g = sb_q.pop_front();
    chk("Haddr1", Haddr1, g.a1);
    chk("Haddr2", Haddr2, g.a2);
    chk("Hwdata1", Hwdata1, g.w1);
    chk("Hwdata2", Hwdata2, g.w2);
    chk("Hwritereg", {31'd0, Hwritereg}, {31'd0, g.wr});
    chk("Hresp", {30'd0, Hresp}, {30'd0, g.resp});
    chk("err_hready", {31'd0, err_hready}, {31'd0, g.hrdy});
  endtask

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSEQ = 2'b10, SEQ = 2'b11;

  initial begin
    // Reset, inputs idle
    step(1, IDLE, 3'd0, 0, 1, 32'h0, 32'h0, 0, 3'b000, 0);
    step(1, IDLE, 3'd0, 0, 1, 32'h0, 32'h0, 0, 3'b000, 0);
    // Write to slave 0, then its data phase
    step(0, NSEQ, 3'd2, 1, 1, 32'h8000_0010, 32'h0, 1, 3'b001, 0);
    step(0, IDLE, 3'd0, 0, 1, 32'h0000_0000, 32'hDEAD_BEEF, 0, 3'b000, 0);
    // Read from slave 2, then stall three cycles
    step(0, NSEQ, 3'd2, 0, 1, 32'h8800_0004, 32'h1234_5678, 1, 3'b100, 0);
    for (int i = 0; i < 3; i++)
      step(0, NSEQ, 3'd2, 1, 0, 32'h8000_0000, 32'hAAAA_0000 + i, 0, 3'b001, 0);
    step(0, IDLE, 3'd0, 0, 1, 32'h0000_0040, 32'h5555_5555, 0, 3'b000, 0);
    // Unmapped: full ERROR sequence
    step(0, NSEQ, 3'd2, 0, 1, 32'h9000_0000, 32'h0, 0, 3'b000, 1);
    step(0, IDLE, 3'd0, 0, 0, 32'h0, 32'h0, 0, 3'b000, 0);
    step(0, IDLE, 3'd0, 0, 1, 32'h0, 32'h0, 0, 3'b000, 0);
    // Misaligned word; legal-looking transfer during ERR1 must be masked;
    // back-to-back misaligned halfword from ERR2; then legal transfer in ERR2
    step(0, NSEQ, 3'd2, 1, 1, 32'h8400_0002, 32'h0, 0, 3'b010, 1);
    step(0, NSEQ, 3'd2, 0, 1, 32'h8000_0000, 32'h0, 0, 3'b001, 0);
    step(0, NSEQ, 3'd1, 0, 1, 32'h8000_0001, 32'h0, 0, 3'b001, 1);
    step(0, IDLE, 3'd0, 0, 0, 32'h0, 32'h0, 0, 3'b000, 0);
    step(0, NSEQ, 3'd2, 1, 1, 32'h8400_0000, 32'h0, 1, 3'b010, 0);
    // BUSY to a mapped address: no valid, no error
    step(0, BUSY, 3'd2, 0, 1, 32'h8000_0000, 32'hCAFE_F00D, 0, 3'b001, 0);
    // Oversized transfer
    step(0, NSEQ, 3'd3, 0, 1, 32'h8000_0000, 32'h0, 0, 3'b001, 1);
    step(0, IDLE, 3'd0, 0, 0, 32'h0, 32'h0, 0, 3'b000, 0);
    step(0, IDLE, 3'd0, 0, 1, 32'h0, 32'h0, 0, 3'b000, 0);
    // Reset while in ERR1 abandons the response
    step(0, NSEQ, 3'd0, 0, 1, 32'h9000_0000, 32'h0, 0, 3'b000, 1);
    step(1, IDLE, 3'd0, 0, 0, 32'h0, 32'h0, 0, 3'b000, 0);
    // Region boundaries and byte access at odd address
    step(0, SEQ,  3'd2, 0, 1, 32'h83FF_FFFC, 32'h1, 1, 3'b001, 0);
    step(0, NSEQ, 3'd2, 1, 1, 32'h8400_0000, 32'h2, 1, 3'b010, 0);
    step(0, NSEQ, 3'd2, 0, 1, 32'h8BFF_FFFC, 32'h3, 1, 3'b100, 0);
    step(0, NSEQ, 3'd0, 0, 1, 32'h8000_0003, 32'h4, 1, 3'b001, 0);
    step(0, NSEQ, 3'd2, 0, 1, 32'h8C00_0000, 32'h5, 0, 3'b000, 1);
    step(0, IDLE, 3'd0, 0, 0, 32'h0, 32'h6, 0, 3'b000, 0);
    step(0, IDLE, 3'd0, 0, 1, 32'h0, 32'h7, 0, 3'b000, 0);
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
